mod4_mult_signed: RTL and testbench
===================================

Name: mod4_mult_signed

Overview:
- Fixed-point multiplier stage that sits directly downstream of mod4_add_signed in the module-4 datapath.
- Consumes the adder's 16-bit Q2.14 result stream on port A and a coefficient stream on port B, and produces their rounded, saturated Q2.14 product.
- Uses the same valid/ready stream handshake and the same sign/overflow conventions as the adder, so the two stages chain directly.

Parameters:
- DATA_WIDTH, 16, width of each operand and of the result.
- FRAC_BITS, 14, fractional bits of the operand and result format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- input_tdata_a  input  DATA_WIDTH  operand A (adder output).
- input_tvalid_a  input  1  operand A valid.
- input_tready_a  output  1  operand A ready.
- input_tdata_b  input  DATA_WIDTH  operand B (coefficient).
- input_tvalid_b  input  1  operand B valid.
- input_tready_b  output  1  operand B ready.
- sign  input  1  1 = two's-complement operands and result; 0 = unsigned.
- output_tdata  output  DATA_WIDTH  rounded, saturated product.
- output_tvalid  output  1  result valid.
- output_tready  input  1  downstream ready.
- overflow  output  1  saturation occurred on the current output beat.

Behaviour:
- Reset: asserting reset clears all stage valids immediately. output_tvalid=0, output_tdata=0, overflow=0, input_tready_a/b=0 while reset is high. Any in-flight beats are discarded; operation resumes on the first clock after reset deasserts.
- Pipeline: three register stages.
  - S1: capture operands and sign.
  - S2: full 2*DATA_WIDTH-bit product with 2*FRAC_BITS fractional bits.
  - S3: round, saturate, and register to the output.
- Latency: 3 cycles from input acceptance to output_tvalid when there is no backpressure. Throughput: 1 beat per cycle.
- Stall enable: en = !output_tvalid || output_tready. When en=0, every stage holds. output_tdata and overflow stay stable while output_tvalid=1 and output_tready=0.
- Input join:
  - input_tready_a = input_tready_b = en && !reset.
  - A beat is accepted only when input_tvalid_a && input_tvalid_b && en.
  - If only one valid is high, nothing is consumed; the other port waits.
  - A bubble advances through the pipeline as valid=0.
- sign is sampled with the operands at acceptance and travels with the beat. A change of sign mid-stream does not affect beats already in flight.
- Arithmetic:
  - Operands are treated as signed or unsigned according to the captured sign.
  - Rounding is round-half-up: add 2^(FRAC_BITS-1) to the raw product, then arithmetic/logical shift right by FRAC_BITS.
  - Signed saturation: result > 2^(DATA_WIDTH-1)-1 clamps to 0x7FFF; result < -2^(DATA_WIDTH-1) clamps to 0x8000.
  - Unsigned saturation: result > 2^DATA_WIDTH-1 clamps to 0xFFFF.
  - overflow=1 exactly on a saturated beat; otherwise 0.
- Simultaneous events: the output handshake (output_tvalid && output_tready) and input acceptance in the same cycle are both legal; the pipeline shifts by one.
- Beats are never dropped or duplicated, and are delivered in order.

Test Plan:
- sign=1, A=0x4000 (1.0), B=0x4000 (1.0), output_tready=1 -> output_tdata=0x4000, overflow=0, output_tvalid rises exactly 3 cycles after acceptance.
- sign=1, A=0x6000 (1.5), B=0x6000 -> 0x7FFF, overflow=1. A=0x8000, B=0x8000 (-2 x -2) -> 0x7FFF, overflow=1. A=0xC000, B=0x2000 -> 0xE000 (-0.5), overflow=0.
- Rounding, sign=1:
  - A=0x0001, B=0x2000 -> 0x0001.
  - A=0xFFFF, B=0x2000 -> 0x0000.
- sign=0, A=0x8000 (2.0), B=0x8000 -> 0xFFFF, overflow=1. A=0x8000, B=0x4000 -> 0x8000, overflow=0.
- Backpressure and join:
  - Hold output_tready=0 for 5 cycles with 4 beats offered -> output_tdata is stable, input_tready drops, and all 4 results emerge in order with none lost.
  - input_tvalid_b=0 with input_tvalid_a=1 -> no beat is accepted.
- Assert reset for 1 cycle with 3 beats in flight -> output_tvalid=0 at once. No stale beat appears afterwards; the next accepted beat completes with 3-cycle latency.

Source files
------------

// File: rtl/mod4_mult_signed_if.sv
// Stream bundle between the module-4 adder/coefficient sources and the multiplier stage.
// Two joined input streams plus sign select, one output stream with overflow flag.
interface mod4_mult_signed_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] input_tdata_a;
  logic                  input_tvalid_a;
  logic                  input_tready_a;
  logic [DATA_WIDTH-1:0] input_tdata_b;
  logic                  input_tvalid_b;
  logic                  input_tready_b;
  logic                  sign;
  logic [DATA_WIDTH-1:0] output_tdata;
  logic                  output_tvalid;
  logic                  output_tready;
  logic                  overflow;

  modport slave (
    input  input_tdata_a, input_tvalid_a, input_tdata_b, input_tvalid_b, sign, output_tready,
    output input_tready_a, input_tready_b, output_tdata, output_tvalid, overflow
  );

  modport master (
    output input_tdata_a, input_tvalid_a, input_tdata_b, input_tvalid_b, sign, output_tready,
    input  input_tready_a, input_tready_b, output_tdata, output_tvalid, overflow
  );
endinterface

// File: rtl/mod4_mult_signed.sv
// Three-stage Q2.14 multiplier: capture, full-width product, round-half-up and saturate.
// Whole pipeline stalls together while the output beat is held by the consumer.
module mod4_mult_signed #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 14
) (
  input  logic                clk,
  input  logic                reset,
  mod4_mult_signed_if.slave   bus
);
  // Two guard bits keep the rounding add and the unsigned range free of wrap.
  localparam int PW = 2*DATA_WIDTH + 2;
  localparam logic signed [PW-1:0] ROUND_BIAS =
    $signed({{(PW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}});
  localparam logic signed [PW-1:0] SMAX = $signed({{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] SMIN = $signed({{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});
  localparam logic signed [PW-1:0] UMAX = $signed({{(PW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}});

  logic                    en;
  logic                    accept;
  logic                    s1_valid;
  logic                    s1_sign;
  logic [DATA_WIDTH-1:0]   s1_a;
  logic [DATA_WIDTH-1:0]   s1_b;
  logic                    s2_valid;
  logic                    s2_sign;
  logic [2*DATA_WIDTH-1:0] s2_prod;
  logic [2*DATA_WIDTH-1:0] prod;
  logic signed [PW-1:0]    rounded;
  logic signed [PW-1:0]    shifted;
  logic [DATA_WIDTH-1:0]   sat_data;
  logic                    sat_ovf;

  assign en                 = !bus.output_tvalid || bus.output_tready;
  assign bus.input_tready_a = en && !reset;
  assign bus.input_tready_b = en && !reset;
  assign accept             = bus.input_tvalid_a && bus.input_tvalid_b && en;

  always_comb begin
    prod = '0;
    if (s1_sign) begin
      prod = $signed({{DATA_WIDTH{s1_a[DATA_WIDTH-1]}}, s1_a}) *
             $signed({{DATA_WIDTH{s1_b[DATA_WIDTH-1]}}, s1_b});
    end else begin
      prod = {{DATA_WIDTH{1'b0}}, s1_a} * {{DATA_WIDTH{1'b0}}, s1_b};
    end
  end

  always_comb begin
    rounded = '0;
    if (s2_sign) begin
      rounded = $signed({{2{s2_prod[2*DATA_WIDTH-1]}}, s2_prod}) + ROUND_BIAS;
    end else begin
      rounded = $signed({2'b00, s2_prod}) + ROUND_BIAS;
    end
    shifted  = rounded >>> FRAC_BITS;
    sat_data = shifted[DATA_WIDTH-1:0];
    sat_ovf  = 1'b0;
    if (s2_sign) begin
      if (shifted > SMAX) begin
        sat_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        sat_ovf  = 1'b1;
      end else if (shifted < SMIN) begin
        sat_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        sat_ovf  = 1'b1;
      end
    end else if (shifted > UMAX) begin
      sat_data = {DATA_WIDTH{1'b1}};
      sat_ovf  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid          <= 1'b0;
      s1_sign           <= 1'b0;
      s1_a              <= '0;
      s1_b              <= '0;
      s2_valid          <= 1'b0;
      s2_sign           <= 1'b0;
      s2_prod           <= '0;
      bus.output_tvalid <= 1'b0;
      bus.output_tdata  <= '0;
      bus.overflow      <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= bus.input_tdata_a;
        s1_b    <= bus.input_tdata_b;
        s1_sign <= bus.sign;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= prod;
        s2_sign <= s1_sign;
      end
      // Bubbles leave the output at zero so a stale overflow never lingers.
      bus.output_tvalid <= s2_valid;
      bus.output_tdata  <= s2_valid ? sat_data : '0;
      bus.overflow      <= s2_valid && sat_ovf;
    end
  end
endmodule

// File: tb/tb_mod4_mult_signed.sv
// Bench for mod4_mult_signed: arithmetic reference model plus scoreboard queue,
// directed vectors, latency, join, backpressure, reset-flush and random traffic.
module tb_mod4_mult_signed;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mod4_mult_signed_if #(.DATA_WIDTH(DW)) bus();
  mod4_mult_signed #(.DATA_WIDTH(DW), .FRAC_BITS(14)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];
  logic        held = 1'b0;
  logic [16:0] held_val;

  // Real-number view: product of the two values, +0.5 LSB, floor, then clamp.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic sg);
    longint p;
    longint r;
    logic [15:0] d;
    logic o;
    if (sg) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'({48'd0, a}) * longint'({48'd0, b});
    r = (p + 64'sd8192) >>> 14;
    d = 16'(r);
    o = 1'b0;
    if (sg) begin
      if (r > 32767)       begin d = 16'h7FFF; o = 1'b1; end
      else if (r < -32768) begin d = 16'h8000; o = 1'b1; end
    end else if (r > 65535) begin
      d = 16'hFFFF; o = 1'b1;
    end
    return {o, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", {12'd0, bus.output_tvalid, bus.input_tready_a, bus.input_tready_b,
                            bus.overflow, bus.output_tdata}, 32'd0);
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held)
        chk("stall_hold", {14'd0, bus.output_tvalid, bus.overflow, bus.output_tdata},
            {14'd0, 1'b1, held_val});
      if (bus.output_tvalid && bus.output_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {15'd0, bus.overflow, bus.output_tdata}, 32'hDEAD);
        end else begin
          chk("out_beat", {15'd0, bus.overflow, bus.output_tdata}, {15'd0, exp_q.pop_front()});
        end
      end
      held     = bus.output_tvalid && !bus.output_tready;
      held_val = {bus.overflow, bus.output_tdata};
      if (bus.input_tvalid_a && bus.input_tvalid_b && bus.input_tready_a)
        exp_q.push_back(model(bus.input_tdata_a, bus.input_tdata_b, bus.sign));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sg);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.input_tdata_a = a;
    bus.input_tdata_b = b;
    bus.sign = sg;
    bus.input_tvalid_a = 1'b1;
    bus.input_tvalid_b = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.input_tready_a;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    chk("send_accepted", {31'd0, acc}, 32'd1);
    bus.input_tvalid_a = 1'b0;
    bus.input_tvalid_b = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.output_tready = 1'b1;
    bus.input_tvalid_a = 1'b0;
    bus.input_tvalid_b = 1'b0;
    while ((exp_q.size() != 0 || bus.output_tvalid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic latency_test(input string name);
    int lat;
    drain();
    bus.input_tdata_a = 16'h4000;
    bus.input_tdata_b = 16'h4000;
    bus.sign = 1'b1;
    bus.input_tvalid_a = 1'b1;
    bus.input_tvalid_b = 1'b1;
    @(negedge clk);
    chk("latency_ready", {31'd0, bus.input_tready_a}, 32'd1);
    @(posedge clk); #1;
    bus.input_tvalid_a = 1'b0;
    bus.input_tvalid_b = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.output_tvalid && lat < 10);
    chk(name, lat, 32'd3);
    chk("latency_data", {15'd0, bus.overflow, bus.output_tdata}, 32'h04000);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corners [9];
    corners = '{16'h0000, 16'h0001, 16'h4000, 16'h6000, 16'h8000,
                16'h7FFF, 16'hFFFF, 16'hC000, 16'h2000};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 8)];
    return 16'($urandom);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;
    logic [15:0] bp_a [4];
    bus.input_tdata_a = '0;
    bus.input_tdata_b = '0;
    bus.input_tvalid_a = 1'b0;
    bus.input_tvalid_b = 1'b0;
    bus.sign = 1'b0;
    bus.output_tready = 1'b1;

    chk("pin_1x1",      {15'd0, model(16'h4000, 16'h4000, 1'b1)}, 32'h04000);
    chk("pin_sat_pos",  {15'd0, model(16'h6000, 16'h6000, 1'b1)}, 32'h17FFF);
    chk("pin_m2xm2",    {15'd0, model(16'h8000, 16'h8000, 1'b1)}, 32'h17FFF);
    chk("pin_neg",      {15'd0, model(16'hC000, 16'h2000, 1'b1)}, 32'h0E000);
    chk("pin_rnd_up",   {15'd0, model(16'h0001, 16'h2000, 1'b1)}, 32'h00001);
    chk("pin_rnd_neg",  {15'd0, model(16'hFFFF, 16'h2000, 1'b1)}, 32'h00000);
    chk("pin_u_sat",    {15'd0, model(16'h8000, 16'h8000, 1'b0)}, 32'h1FFFF);
    chk("pin_u_nosat",  {15'd0, model(16'h8000, 16'h4000, 1'b0)}, 32'h08000);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    latency_test("latency_first");

    send(16'h6000, 16'h6000, 1'b1);
    send(16'h8000, 16'h8000, 1'b1);
    send(16'hC000, 16'h2000, 1'b1);
    send(16'h0001, 16'h2000, 1'b1);
    send(16'hFFFF, 16'h2000, 1'b1);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'h8000, 16'h4000, 1'b0);
    drain();

    bus.input_tvalid_a = 1'b1;
    bus.input_tvalid_b = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("join_no_output", {31'd0, bus.output_tvalid}, 32'd0);
    chk("join_ready_offered", {31'd0, bus.input_tready_b}, 32'd1);
    @(posedge clk); #1;
    bus.input_tvalid_a = 1'b0;

    bp_a = '{16'h1000, 16'hE000, 16'h7FFF, 16'h2345};
    bus.output_tready = 1'b0;
    bus.sign = 1'b1;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      bus.input_tdata_a = bp_a[idx];
      bus.input_tdata_b = 16'h3000;
      bus.input_tvalid_a = 1'b1;
      bus.input_tvalid_b = 1'b1;
      @(negedge clk);
      if (bus.input_tready_a) idx++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", idx, 32'd3);
    @(negedge clk);
    chk("bp_tready_low", {31'd0, bus.input_tready_a}, 32'd0);
    @(posedge clk); #1;
    bus.output_tready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      bus.input_tdata_a = bp_a[idx];
      @(negedge clk);
      if (bus.input_tready_a) idx++;
      @(posedge clk); #1;
      n++;
    end
    chk("bp_all_accepted", idx, 32'd4);
    drain();

    send(16'h1111, 16'h4000, 1'b1);
    send(16'h2222, 16'h4000, 1'b0);
    send(16'h3333, 16'h4000, 1'b1);
    reset = 1'b1;
    #1;
    chk("reset_immediate", {30'd0, bus.output_tvalid, bus.input_tready_a}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    latency_test("latency_after_reset");
    drain();

    for (int c = 0; c < 400; c++) begin
      bus.input_tdata_a = pick();
      bus.input_tdata_b = pick();
      bus.sign = 1'($urandom_range(0, 1));
      bus.input_tvalid_a = ($urandom_range(0, 3) != 0);
      bus.input_tvalid_b = ($urandom_range(0, 3) != 0);
      bus.output_tready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
